// File: rtl/doorlock_pkg.sv
// Shared definitions for the keypad door lock: FSM states, key codes, timer sizing.
package doorlock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_SET_NEW,
    ST_LOCKOUT
  } state_e;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_SET       = 4'hC;
  localparam logic [3:0] KEY_LOCK      = 4'hD;

  // The timer holds (cycles - 1), so clog2 of the longer period is always enough.
  function automatic int timer_width(input int open_cycles, input int lock_cycles);
    int longest;
    longest = (open_cycles > lock_cycles) ? open_cycles : lock_cycles;
    return (longest <= 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/doorlock_timer.sv
// Loadable down-counter; done is high while the count is zero.
module doorlock_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// Keypad sequencer: gates digits into the input buffer, checks codes, unlocks, locks out.
// Optional alarm output built when DOORLOCK_ALARM_EN is defined.
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int           OPEN_CYCLES = 1000,
  parameter int           LOCK_CYCLES = 5000,
  parameter int           MAX_FAILS   = 3,
  parameter int           MIN_DIGITS  = 4,
  parameter int           MAX_DIGITS  = 32,
  parameter logic [127:0] DEFAULT_PW  = {{112{1'b1}}, 16'h1234}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_v,
  input  logic [3:0]   key,
  input  logic [127:0] buf_data,
  output logic         decision,
  output logic         buff_rst,
  output logic         unlock,
  output logic         locked_out,
  output logic [2:0]   fail_cnt
`ifdef DOORLOCK_ALARM_EN
  ,
  output logic         alarm
`endif
);

  localparam int            TW        = timer_width(OPEN_CYCLES, LOCK_CYCLES);
  localparam int            DW        = $clog2(MAX_DIGITS + 1);
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [DW-1:0] MAX_D     = DW'(MAX_DIGITS);
  localparam logic [DW-1:0] MIN_D     = DW'(MIN_DIGITS);
  localparam logic [2:0]    MAX_F     = 3'(MAX_FAILS);

  state_e         state_q, state_d;
  logic [DW-1:0]  digit_cnt_q, digit_cnt_d;
  logic [2:0]     fail_cnt_q, fail_cnt_d;
  logic [127:0]   pw_q, pw_d;
  logic           buff_rst_q, buff_rst_d;
  logic           unlock_q, unlock_d;
  logic           locked_out_q, locked_out_d;
  logic           key_ok, match, tmr_load, tmr_done;
  logic [TW-1:0]  tmr_val;

  // key_v is a one-cycle strobe with no back-pressure; decision is the same-cycle accept
  // for the buffer. Any key arriving while the buffer is being cleared is dropped.
  assign key_ok   = key_v & ~buff_rst_q;
  assign decision = key_ok & (key <= KEY_MAX_DIGIT)
                  & ((state_q == ST_ENTRY) | (state_q == ST_SET_NEW))
                  & (digit_cnt_q < MAX_D);
  assign match    = (buf_data == pw_q) & (digit_cnt_q >= MIN_D);

  always_comb begin
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    pw_d        = pw_q;
    buff_rst_d  = 1'b0;
    if (decision) digit_cnt_d = digit_cnt_q + DW'(1);
    case (state_q)
      ST_ENTRY: begin
        if (key_ok && key == KEY_CLEAR) begin
          buff_rst_d  = 1'b1;
          digit_cnt_d = '0;
        end else if (key_ok && key == KEY_ENTER) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        buff_rst_d  = 1'b1;
        digit_cnt_d = '0;
        if (match) begin
          state_d    = ST_OPEN;
          fail_cnt_d = '0;
        end else begin
          fail_cnt_d = fail_cnt_q + 3'd1;
          state_d    = (fail_cnt_q + 3'd1 == MAX_F) ? ST_LOCKOUT : ST_ENTRY;
        end
      end
      ST_OPEN: begin
        if (tmr_done) begin
          state_d = ST_ENTRY;
        end else if (key_ok && key == KEY_LOCK) begin
          state_d = ST_ENTRY;
        end else if (key_ok && key == KEY_SET) begin
          state_d = ST_SET_NEW;
        end
      end
      ST_SET_NEW: begin
        if (key_ok && (key == KEY_CLEAR || key == KEY_ENTER || key == KEY_LOCK)) begin
          buff_rst_d  = 1'b1;
          digit_cnt_d = '0;
          if (key == KEY_LOCK) begin
            state_d = ST_ENTRY;
          end else if (key == KEY_ENTER && digit_cnt_q >= MIN_D) begin
            pw_d    = buf_data;
            state_d = ST_ENTRY;
          end
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d    = ST_ENTRY;
          fail_cnt_d = '0;
          buff_rst_d = 1'b1;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
    unlock_d     = (state_d == ST_OPEN);
    locked_out_d = (state_d == ST_LOCKOUT);
  end

  // The timer is reloaded on the CHECK edge, so it starts counting on the first cycle
  // of OPEN or LOCKOUT.
  assign tmr_load = (state_q == ST_CHECK);
  assign tmr_val  = match ? OPEN_LOAD : LOCK_LOAD;

  doorlock_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_val),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ENTRY;
      digit_cnt_q  <= '0;
      fail_cnt_q   <= '0;
      pw_q         <= DEFAULT_PW;
      buff_rst_q   <= 1'b1;
      unlock_q     <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_cnt_q  <= digit_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      pw_q         <= pw_d;
      buff_rst_q   <= buff_rst_d;
      unlock_q     <= unlock_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign buff_rst   = buff_rst_q;
  assign unlock     = unlock_q;
  assign locked_out = locked_out_q;
  assign fail_cnt   = fail_cnt_q;

`ifdef DOORLOCK_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (state_q == ST_CHECK) begin
      if (match) alarm_d = 1'b0;
      else if (state_d == ST_LOCKOUT) alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed scenarios plus random code entries against a digit-queue model.
module tb_doorlock_ctrl;
  import doorlock_pkg::*;

  localparam int OPEN_C = 1000;
  localparam int LOCK_C = 5000;
  localparam int M_ENTRY = 0, M_OPEN = 1, M_SET = 2, M_LOCK = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_v = 1'b0;
  logic [3:0]   key = 4'h0;
  logic [127:0] ibuf;
  logic         decision, buff_rst, unlock, locked_out;
  logic [2:0]   fail_cnt;
`ifdef DOORLOCK_ALARM_EN
  logic         alarm;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: what the user has typed and the password, both as digit sequences.
  logic [3:0] typed_q[$];
  logic [3:0] pw_q[$];
  logic [0:0] exp_q[$];
  int         m_mode;
  int         m_fails;
  bit         m_alarm;
  bit         auto_wait = 1'b1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  doorlock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_v      (key_v),
    .key        (key),
    .buf_data   (ibuf),
    .decision   (decision),
    .buff_rst   (buff_rst),
    .unlock     (unlock),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
`ifdef DOORLOCK_ALARM_EN
    ,
    .alarm      (alarm)
`endif
  );

  // Input buffer the controller drives: shift-in on decision, refill with 0xF on clear.
  always @(posedge clk) begin
    if (buff_rst)      ibuf <= '1;
    else if (decision) ibuf <= {ibuf[123:0], key};
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_alarm(input string tag);
`ifdef DOORLOCK_ALARM_EN
    chk(tag, alarm, m_alarm);
`else
    if (tag.len() == 0) $display("alarm feature not built");
`endif
  endtask

  function automatic bit code_matches();
    if (typed_q.size() < 4 || typed_q.size() != pw_q.size()) return 1'b0;
    foreach (typed_q[i]) if (typed_q[i] != pw_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_v = 1'b0;
    #1;
    typed_q.delete();
    pw_q = '{4'h1, 4'h2, 4'h3, 4'h4};
    m_mode = M_ENTRY;
    m_fails = 0;
    m_alarm = 1'b0;
    chk("rst_buff_rst", buff_rst, 1);
    chk("rst_unlock", unlock, 0);
    chk("rst_locked_out", locked_out, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    chk_alarm("rst_alarm");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_buff_rst_hold", buff_rst, 1);
    @(negedge clk);
    chk("rel_buff_rst_drop", buff_rst, 0);
  endtask

  // One key strobe for a cycle, then one idle cycle; returns on the negedge after the key edge.
  task automatic press(input logic [3:0] k);
    logic exp_dec;
    exp_dec = ((m_mode == M_ENTRY) || (m_mode == M_SET)) && (k <= 4'd9) && (typed_q.size() < 32);
    exp_q.push_back(exp_dec);
    @(negedge clk);
    key_v = 1'b1;
    key = k;
    #1 chk("decision", decision, exp_q.pop_front());
    if (exp_dec) typed_q.push_back(k);
    @(negedge clk);
    key_v = 1'b0;
  endtask

  task automatic wait_open();
    int cnt = 0;
    int pulses = 0;
    while (unlock === 1'b1 && cnt < OPEN_C + 100) begin
      if (buff_rst === 1'b1) pulses++;
      cnt++;
      @(negedge clk);
    end
    chk("open_len", cnt, OPEN_C);
    chk("open_buff_rst_pulses", pulses, 1);
    m_mode = M_ENTRY;
  endtask

  task automatic wait_lockout();
    int cnt = 0;
    while (locked_out === 1'b1 && cnt < LOCK_C + 100) begin
      if (cnt < 16) begin
        key_v = 1'b1;
        key = 4'($urandom_range(0, 15));
        #1 chk("lock_decision", decision, 0);
      end else begin
        key_v = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    key_v = 1'b0;
    m_mode = M_ENTRY;
    m_fails = 0;
    chk("lock_len", cnt, LOCK_C);
    chk("lock_exit_buff_rst", buff_rst, 1);
    chk("lock_exit_fail_cnt", fail_cnt, 0);
    chk_alarm("lock_exit_alarm");
  endtask

  task automatic do_key(input logic [3:0] k);
    bit ok;
    press(k);
    if (k == KEY_CLEAR && (m_mode == M_ENTRY || m_mode == M_SET)) begin
      typed_q.delete();
      chk("clear_buff_rst", buff_rst, 1);
    end else if (k == KEY_ENTER && m_mode == M_ENTRY) begin
      ok = code_matches();
      typed_q.delete();
      @(negedge clk);
      chk("check_buff_rst", buff_rst, 1);
      if (ok) begin
        m_mode = M_OPEN;
        m_fails = 0;
        m_alarm = 1'b0;
        chk("match_unlock", unlock, 1);
      end else begin
        m_fails++;
        chk("miss_unlock", unlock, 0);
        if (m_fails == 3) begin
          m_mode = M_LOCK;
          m_alarm = 1'b1;
        end
      end
      chk("check_fail_cnt", fail_cnt, m_fails);
      chk("check_locked_out", locked_out, (m_mode == M_LOCK) ? 1 : 0);
      chk_alarm("check_alarm");
      if (m_mode == M_LOCK && auto_wait) wait_lockout();
    end else if (k == KEY_ENTER && m_mode == M_SET) begin
      if (typed_q.size() >= 4) begin
        pw_q = typed_q;
        m_mode = M_ENTRY;
      end
      typed_q.delete();
      chk("set_buff_rst", buff_rst, 1);
      chk("set_unlock", unlock, 0);
    end else if (k == KEY_LOCK && m_mode == M_SET) begin
      typed_q.delete();
      m_mode = M_ENTRY;
      chk("abort_buff_rst", buff_rst, 1);
    end else if (k == KEY_SET && m_mode == M_OPEN) begin
      m_mode = M_SET;
      chk("to_set_unlock", unlock, 0);
    end else if (k == KEY_LOCK && m_mode == M_OPEN) begin
      m_mode = M_ENTRY;
      chk("relock_unlock", unlock, 0);
    end
  endtask

  task automatic type_code(input logic [31:0] code, input int n);
    for (int i = n - 1; i >= 0; i--) do_key(code[i*4 +: 4]);
  endtask

  task automatic type_pw();
    logic [3:0] cp[$];
    cp = pw_q;
    foreach (cp[i]) do_key(cp[i]);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int kind;
    int len;
    do_reset();

    // Default password opens and holds for the full open time.
    type_code(32'h1234, 4);
    do_key(KEY_ENTER);
    chk("open_mode", m_mode, M_OPEN);
    wait_open();

    // Three wrong codes lock the keypad out; then the right code still works.
    repeat (3) begin
      type_code(32'h9999, 4);
      do_key(KEY_ENTER);
    end
    type_code(32'h1234, 4);
    do_key(KEY_ENTER);
    do_key(KEY_LOCK);

    // Password change to 5678.
    type_code(32'h1234, 4);
    do_key(KEY_ENTER);
    do_key(KEY_SET);
    type_code(32'h5678, 4);
    do_key(KEY_ENTER);
    type_code(32'h1234, 4);
    do_key(KEY_ENTER);
    type_code(32'h5678, 4);
    do_key(KEY_ENTER);
    chk("new_pw_open", unlock, 1);
    do_key(KEY_LOCK);

    // Overlong entry: the 33rd digit is not accepted; then clear-and-retype opens.
    repeat (33) do_key(4'($urandom_range(0, 9)));
    do_key(KEY_ENTER);
    type_code(32'h12, 2);
    do_key(KEY_CLEAR);
    type_pw();
    do_key(KEY_ENTER);
    chk("clear_then_open", unlock, 1);
    do_key(KEY_LOCK);

    // Random entries, occasionally changing the password while open.
    repeat (14) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        type_pw();
      end else if (kind == 1) begin
        len = $urandom_range(1, 6);
        repeat (len) do_key(4'($urandom_range(0, 9)));
      end else if (kind == 2) begin
        repeat (3) do_key(4'($urandom_range(0, 9)));
        do_key(KEY_CLEAR);
        type_pw();
      end else begin
        typed_q.delete();
        foreach (pw_q[i]) do_key((i == 0) ? 4'((pw_q[i] + 4'd1) % 10) : pw_q[i]);
      end
      do_key(KEY_ENTER);
      if (m_mode == M_OPEN) begin
        if ($urandom_range(0, 1) == 1) begin
          do_key(KEY_SET);
          len = $urandom_range(3, 6);
          repeat (len) do_key(4'($urandom_range(0, 9)));
          do_key(KEY_ENTER);
          if (m_mode == M_SET) do_key(KEY_LOCK);
        end else begin
          do_key(KEY_LOCK);
        end
      end
    end

    // Reset in the middle of OPEN, then in the middle of LOCKOUT.
    type_pw();
    do_key(KEY_ENTER);
    repeat (50) @(negedge clk);
    chk("mid_open_unlock", unlock, (m_mode == M_OPEN) ? 1 : 0);
    do_reset();
    auto_wait = 1'b0;
    while (m_mode != M_LOCK) begin
      type_code(32'h0000, 4);
      do_key(KEY_ENTER);
    end
    repeat (100) @(negedge clk);
    chk("mid_lock_locked_out", locked_out, 1);
    do_reset();
    auto_wait = 1'b1;
    type_code(32'h1234, 4);
    do_key(KEY_ENTER);
    chk("post_reset_default_pw", unlock, 1);
    chk_alarm("post_reset_alarm");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
